// File: rtl/store_buf_pkg.sv
// -----------------------------------------------------------------------------
// store_buf_pkg
// Types and constants shared by the data-memory store buffer and its FIFO.
//   drain_state_e : state of the external-memory drain FSM (IDLE, REQ)
//   st_entry_t    : one buffered store (address + data) at default widths
//   DEFAULT_*     : default geometry of the buffer
// -----------------------------------------------------------------------------
package store_buf_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } st_entry_t;

endpackage

// File: rtl/store_buf_fifo.sv
// -----------------------------------------------------------------------------
// store_buf_fifo
// Circular store queue: entry storage, read/write pointers, occupancy count.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   push_s          : write push_entry_s at the tail (caller guarantees !full)
//   push_entry_s    : entry to enqueue
//   pop_s           : retire the head entry (caller guarantees !empty)
//   head_s          : entry at the read pointer
//   next_head_s     : entry one past the read pointer
//   entries_s       : whole storage array (for forwarding lookups)
//   rd_ptr_s        : read pointer
//   count_s         : number of valid entries, 0..DEPTH
//   full_s, empty_s : occupancy flags, decoded from the count register
// Entry storage is intentionally not reset; only pointers and count are.
// -----------------------------------------------------------------------------
module store_buf_fifo
    import store_buf_pkg::*;
#(
    parameter int  DEPTH     = DEFAULT_DEPTH,
    parameter int  PTR_WIDTH = $clog2(DEPTH),
    parameter type entry_t   = st_entry_t
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_s,
    input  entry_t               push_entry_s,
    input  logic                 pop_s,
    output entry_t               head_s,
    output entry_t               next_head_s,
    output entry_t [DEPTH-1:0]   entries_s,
    output logic [PTR_WIDTH-1:0] rd_ptr_s,
    output logic [PTR_WIDTH:0]   count_s,
    output logic                 full_s,
    output logic                 empty_s
);

    localparam logic [PTR_WIDTH:0]   CNT_DEPTH = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE   = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

    entry_t [DEPTH-1:0]   mem_r;
    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic [PTR_WIDTH:0]   count_r;

    // Entry storage: written on push only, no reset (contents are don't-care when invalid).
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {(PTR_WIDTH+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s      = mem_r[rd_ptr_r];
    assign next_head_s = mem_r[rd_ptr_r + PTR_ONE];
    assign entries_s   = mem_r;
    assign rd_ptr_s    = rd_ptr_r;
    assign count_s     = count_r;
    assign full_s      = (count_r == CNT_DEPTH);
    assign empty_s     = (count_r == {(PTR_WIDTH+1){1'b0}});

endmodule

// File: rtl/data_mem_store_buffer.sv
// -----------------------------------------------------------------------------
// data_mem_store_buffer
// Store buffer between the single-cycle MIPS core data port and a slow
// external data memory. Core stores retire in one cycle into a FIFO; a drain
// FSM writes them out in program order over a MEM_REQ/MEM_ACK handshake.
// The core is stalled only while the FIFO is full.
//
// Configuration macro: STORE_BUF_FWD_EN
//   defined   : combinational store-to-load forwarding (youngest match wins)
//   undefined : FWD_HIT/FWD_DATA tied to zero, no comparators
//
// Ports:
//   CLK, RST_N          : clock (rising edge), asynchronous active-low reset
//   ST_EN/ADDR/DATA     : core store request (DATA_MEM_WR_EN/ALU_Result/RD2)
//   ST_STALL            : buffer full, core must hold PC and the store
//   LD_ADDR             : core load address for forwarding lookup
//   FWD_HIT, FWD_DATA   : forwarding result
//   MEM_REQ/ADDR/WDATA  : external write request (registered)
//   MEM_ACK             : external write accepted
//   EMPTY               : no pending stores
// -----------------------------------------------------------------------------
module data_mem_store_buffer
    import store_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ST_EN,
    input  logic [ADDR_WIDTH-1:0] ST_ADDR,
    input  logic [DATA_WIDTH-1:0] ST_DATA,
    output logic                  ST_STALL,
    input  logic [ADDR_WIDTH-1:0] LD_ADDR,
    output logic                  FWD_HIT,
    output logic [DATA_WIDTH-1:0] FWD_DATA,
    output logic                  MEM_REQ,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic                  MEM_ACK,
    output logic                  EMPTY
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam logic [PTR_WIDTH:0] CNT_ONE = (PTR_WIDTH+1)'(1);

    entry_t               push_entry_s;
    entry_t               head_s;
    entry_t               next_head_s;
    entry_t [DEPTH-1:0]   entries_s;
    logic [PTR_WIDTH-1:0] rd_ptr_s;
    logic [PTR_WIDTH:0]   count_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;

    drain_state_e          state_r;
    logic                  mem_req_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;

    // A store arriving while full is dropped here; the core re-presents it
    // because ST_STALL holds it, so it lands the cycle after the next pop.
    assign push_s       = ST_EN & ~full_s;
    assign pop_s        = (state_r == REQ) & MEM_ACK;
    assign push_entry_s = '{addr: ST_ADDR, data: ST_DATA};

    store_buf_fifo #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .entry_t   (entry_t)
    ) u_fifo (
        .clk          (CLK),
        .rst_n        (RST_N),
        .push_s       (push_s),
        .push_entry_s (push_entry_s),
        .pop_s        (pop_s),
        .head_s       (head_s),
        .next_head_s  (next_head_s),
        .entries_s    (entries_s),
        .rd_ptr_s     (rd_ptr_s),
        .count_s      (count_s),
        .full_s       (full_s),
        .empty_s      (empty_s)
    );

    // Drain FSM: presents the head entry and holds it until acknowledged;
    // chains straight into the next entry when more than one is pending.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        mem_addr_r  <= head_s.addr;
                        mem_wdata_r <= head_s.data;
                        mem_req_r   <= 1'b1;
                        state_r     <= REQ;
                    end
                end
                REQ: begin
                    if (MEM_ACK) begin
                        // count_s is the pre-pop occupancy; a same-cycle push
                        // is not yet visible and is picked up from IDLE.
                        if (count_s > CNT_ONE) begin
                            mem_addr_r  <= next_head_s.addr;
                            mem_wdata_r <= next_head_s.data;
                        end else begin
                            mem_req_r <= 1'b0;
                            state_r   <= IDLE;
                        end
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign MEM_REQ   = mem_req_r;
    assign MEM_ADDR  = mem_addr_r;
    assign MEM_WDATA = mem_wdata_r;
    assign ST_STALL  = full_s;
    assign EMPTY     = empty_s;

`ifdef STORE_BUF_FWD_EN
    logic                  fwd_hit_s;
    logic [DATA_WIDTH-1:0] fwd_data_s;
    logic [PTR_WIDTH-1:0]  fwd_idx_s;

    // Forwarding search: walk oldest to youngest valid entry so the last
    // (youngest) address match overrides earlier ones.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_WIDTH{1'b0}};
        fwd_idx_s  = rd_ptr_s;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = rd_ptr_s + PTR_WIDTH'(i);
            if (((PTR_WIDTH+1)'(i) < count_s) && (entries_s[fwd_idx_s].addr == LD_ADDR)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = entries_s[fwd_idx_s].data;
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign FWD_HIT  = fwd_hit_s;
    assign FWD_DATA = fwd_data_s;
`else
    logic unused_fwd_s;

    // Lookup inputs are intentionally ignored when forwarding is compiled out.
    assign unused_fwd_s = ^{LD_ADDR, entries_s, rd_ptr_s};
    assign FWD_HIT      = 1'b0;
    assign FWD_DATA     = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_data_mem_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_data_mem_store_buffer
// Directed, self-checking bench for data_mem_store_buffer (DEPTH=4).
// Expected values are hand-derived from the cycle behaviour of the buffer.
// -----------------------------------------------------------------------------
module tb_data_mem_store_buffer;

    logic        CLK;
    logic        RST_N;
    logic        ST_EN;
    logic [31:0] ST_ADDR;
    logic [31:0] ST_DATA;
    logic        ST_STALL;
    logic [31:0] LD_ADDR;
    logic        FWD_HIT;
    logic [31:0] FWD_DATA;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK;
    logic        EMPTY;

    int checks = 0;
    int errors = 0;

    data_mem_store_buffer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ST_EN     (ST_EN),
        .ST_ADDR   (ST_ADDR),
        .ST_DATA   (ST_DATA),
        .ST_STALL  (ST_STALL),
        .LD_ADDR   (LD_ADDR),
        .FWD_HIT   (FWD_HIT),
        .FWD_DATA  (FWD_DATA),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_ACK   (MEM_ACK),
        .EMPTY     (EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        ST_EN   = 1'b1;
        ST_ADDR = a;
        ST_DATA = d;
    endtask

    initial begin
        RST_N   = 1'b0;
        ST_EN   = 1'b0;
        ST_ADDR = 32'd0;
        ST_DATA = 32'd0;
        LD_ADDR = 32'd0;
        MEM_ACK = 1'b0;
        #2;
        check("rst_req",   {31'd0, MEM_REQ},  32'd0);
        check("rst_addr",  MEM_ADDR,          32'd0);
        check("rst_wdata", MEM_WDATA,         32'd0);
        check("rst_stall", {31'd0, ST_STALL}, 32'd0);
        check("rst_empty", {31'd0, EMPTY},    32'd1);
        check("rst_fwd",   {31'd0, FWD_HIT},  32'd0);
        check("rst_fdata", FWD_DATA,          32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        step();

        // ---- single store, ack tied high ----
        MEM_ACK = 1'b1;
        store(32'd84, 32'd7);
        step();
        ST_EN = 1'b0;
        check("t1_push_noreq", {31'd0, MEM_REQ}, 32'd0);
        check("t1_push_nempty", {31'd0, EMPTY},  32'd0);
        step();
        check("t1_req",   {31'd0, MEM_REQ}, 32'd1);
        check("t1_addr",  MEM_ADDR,         32'd84);
        check("t1_wdata", MEM_WDATA,        32'd7);
        step();
        check("t1_empty", {31'd0, EMPTY},   32'd1);
        check("t1_noreq", {31'd0, MEM_REQ}, 32'd0);

        // ---- full stall with ack held low ----
        MEM_ACK = 1'b0;
        store(32'd80, 32'd180); step();
        store(32'd84, 32'd184); step();
        check("t2_req_head", MEM_ADDR, 32'd80);
        store(32'd88, 32'd188); step();
        check("t2_stall3", {31'd0, ST_STALL}, 32'd0);
        store(32'd92, 32'd192); step();
        check("t2_stall4", {31'd0, ST_STALL}, 32'd1);
        store(32'd96, 32'd196); step();
        check("t2_stall_hold", {31'd0, ST_STALL}, 32'd1);
        check("t2_head_hold",  MEM_ADDR,          32'd80);
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        check("t2_stall_drop", {31'd0, ST_STALL}, 32'd0);
        check("t2_next_head",  MEM_ADDR,          32'd84);
        step();
        ST_EN = 1'b0;
        check("t2_96_pushed", {31'd0, ST_STALL}, 32'd1);
        MEM_ACK = 1'b1;
        check("t2_d84", MEM_ADDR, 32'd84);
        step();
        check("t2_d88", MEM_ADDR, 32'd88);
        step();
        check("t2_d92", MEM_ADDR, 32'd92);
        step();
        check("t2_d96",  MEM_ADDR,  32'd96);
        check("t2_w196", MEM_WDATA, 32'd196);
        step();
        check("t2_empty", {31'd0, EMPTY},   32'd1);
        check("t2_noreq", {31'd0, MEM_REQ}, 32'd0);

        // ---- back-to-back drain, two batches (second crosses the pointer wrap) ----
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 6; k++) begin
                if (k < 4) store(32'd80 + 32'(4 * k), 32'(100 * b + k));
                else       ST_EN = 1'b0;
                step();
                if (k >= 1 && k <= 4) begin
                    check("t3_req",   {31'd0, MEM_REQ}, 32'd1);
                    check("t3_addr",  MEM_ADDR,         32'd80 + 32'(4 * (k - 1)));
                    check("t3_wdata", MEM_WDATA,        32'(100 * b + k - 1));
                end else begin
                    check("t3_noreq", {31'd0, MEM_REQ}, 32'd0);
                end
            end
            ST_EN = 1'b0;
            check("t3_empty", {31'd0, EMPTY}, 32'd1);
        end

        // ---- delayed ack: request held stable, push does not disturb head ----
        MEM_ACK = 1'b0;
        store(32'd200, 32'hA); step();
        ST_EN = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("t4_req",   {31'd0, MEM_REQ}, 32'd1);
            check("t4_addr",  MEM_ADDR,         32'd200);
            check("t4_wdata", MEM_WDATA,        32'hA);
            if (i == 0) store(32'd204, 32'hB);
            step();
            ST_EN = 1'b0;
        end
        check("t4_addr_end", MEM_ADDR, 32'd200);
        MEM_ACK = 1'b1;
        step();
        check("t4_addr2",  MEM_ADDR,  32'd204);
        check("t4_wdata2", MEM_WDATA, 32'hB);
        step();
        MEM_ACK = 1'b0;
        check("t4_empty", {31'd0, EMPTY}, 32'd1);

        // ---- forwarding with ack held low ----
        store(32'd84, 32'd7); step();
        LD_ADDR = 32'd84;
        #1;
`ifdef STORE_BUF_FWD_EN
        check("t5_hit1",  {31'd0, FWD_HIT}, 32'd1);
        check("t5_data1", FWD_DATA,         32'd7);
`else
        check("t5_hit1",  {31'd0, FWD_HIT}, 32'd0);
        check("t5_data1", FWD_DATA,         32'd0);
`endif
        store(32'd84, 32'd9);
        step();
        ST_EN = 1'b0;
        #1;
`ifdef STORE_BUF_FWD_EN
        check("t5_hit2",  {31'd0, FWD_HIT}, 32'd1);
        check("t5_data2", FWD_DATA,         32'd9);
`else
        check("t5_hit2",  {31'd0, FWD_HIT}, 32'd0);
        check("t5_data2", FWD_DATA,         32'd0);
`endif
        LD_ADDR = 32'd80;
        #1;
        check("t5_miss", {31'd0, FWD_HIT}, 32'd0);

        // ---- reset in REQ with three entries pending ----
        step();
        store(32'd92, 32'd5);
        step();
        ST_EN = 1'b0;
        check("t6_pre_req",   {31'd0, MEM_REQ}, 32'd1);
        check("t6_pre_nempty", {31'd0, EMPTY},  32'd0);
        RST_N = 1'b0;
        #1;
        check("t6_rst_req",   {31'd0, MEM_REQ}, 32'd0);
        check("t6_rst_empty", {31'd0, EMPTY},   32'd1);
        check("t6_rst_addr",  MEM_ADDR,         32'd0);
        @(negedge CLK);
        RST_N   = 1'b1;
        MEM_ACK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_idle_req", {31'd0, MEM_REQ}, 32'd0);
        end
        store(32'd300, 32'h33);
        step();
        ST_EN = 1'b0;
        check("t6_new_noreq", {31'd0, MEM_REQ}, 32'd0);
        step();
        check("t6_new_req",   {31'd0, MEM_REQ}, 32'd1);
        check("t6_new_addr",  MEM_ADDR,         32'd300);
        check("t6_new_wdata", MEM_WDATA,        32'h33);
        step();
        check("t6_new_empty", {31'd0, EMPTY}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
